rvlab_clk_drp_seq: RTL and testbench

Sequences MMCM dynamic reconfiguration of CLKOUT0 (sys_clk) from a single "set divider" request.
- Accepts an integer divider and holds the MMCM in reset.
- Performs read-modify-write of ClkReg1/ClkReg2 over DRP, then releases reset and waits for lock.
- Sits between the clock-manager register front-end and the MMCM DRP port. Runs on the fixed 100 MHz clock domain.

---
 rtl/rvlab_clk_drp_pkg.sv | 47 ++++
 rtl/rvlab_clk_div_encode.sv | 26 ++
 rtl/rvlab_clk_drp_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_rvlab_clk_drp_seq.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvlab_clk_drp_pkg.sv
// rvlab_clk_drp_pkg: shared types and MMCME2 CLKOUT0 register layout
// for the sys_clk reconfiguration sequencer.
package rvlab_clk_drp_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HOLD_RST,
    S_RD1,
    S_WAIT_R1,
    S_WR1,
    S_WAIT_W1,
    S_RD2,
    S_WAIT_R2,
    S_WR2,
    S_WAIT_W2,
    S_RELEASE,
    S_WAIT_LOCK
  } state_e;

  typedef enum logic [1:0] {
    ErrNone,
    ErrBadDiv,
    ErrDrpTimeout,
    ErrLockTimeout
  } err_e;

  localparam logic [6:0]  CLKREG1_ADDR_DEF = 7'h08;
  localparam logic [6:0]  CLKREG2_ADDR_DEF = 7'h09;
  localparam logic [15:0] CLKREG1_KEEP_DEF = 16'h1000;
  localparam logic [15:0] CLKREG2_KEEP_DEF = 16'hFC00;

  localparam int HIGH_OFS  = 6;
  localparam int LOW_OFS   = 0;
  localparam int EDGE_OFS  = 7;
  localparam int NOCNT_OFS = 6;

  localparam logic [7:0] DIV_MAX = 8'd126;

  typedef struct packed {
    logic [5:0] high;
    logic [5:0] low;
    logic       edge_bit;
    logic       no_count;
    logic       valid;
  } div_fields_t;

endpackage

// File: rtl/rvlab_clk_div_encode.sv
// rvlab_clk_div_encode: integer divider to MMCME2 high/low/edge/no_count
// fields; shared by any CLKOUT or feedback divider.
module rvlab_clk_div_encode
  import rvlab_clk_drp_pkg::*;
(
  input  logic [7:0]  div_i,
  output div_fields_t fields_o
);

  always_comb begin
    fields_o.valid = (div_i != 8'd0) && (div_i <= DIV_MAX);
    if (div_i == 8'd1) begin
      fields_o.high     = 6'd1;
      fields_o.low      = 6'd1;
      fields_o.edge_bit = 1'b0;
      fields_o.no_count = 1'b1;
    end else begin
      // low = d - (d >> 1), i.e. the rounded-up half
      fields_o.high     = div_i[6:1];
      fields_o.low      = div_i[6:1] + 6'(div_i[0]);
      fields_o.edge_bit = div_i[0];
      fields_o.no_count = 1'b0;
    end
  end

endmodule

// File: rtl/rvlab_clk_drp_seq.sv
// rvlab_clk_drp_seq: holds the MMCM in reset, read-modify-writes the
// CLKOUT0 divider registers over DRP, then releases and waits for lock.
module rvlab_clk_drp_seq
  import rvlab_clk_drp_pkg::*;
#(
  parameter logic [6:0]  CLKREG1_ADDR = CLKREG1_ADDR_DEF,
  parameter logic [6:0]  CLKREG2_ADDR = CLKREG2_ADDR_DEF,
  parameter logic [15:0] CLKREG1_KEEP = CLKREG1_KEEP_DEF,
  parameter logic [15:0] CLKREG2_KEEP = CLKREG2_KEEP_DEF,
  parameter logic [7:0]  RESET_DIV    = 8'd18,
  parameter int unsigned RST_CYCLES   = 4,
  parameter int unsigned DRDY_TIMEOUT = 64,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [7:0]  req_div_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  err_o,
  output logic [7:0]  cur_div_o,
  output logic        drp_den_o,
  output logic        drp_dwe_o,
  output logic [6:0]  drp_daddr_o,
  output logic [15:0] drp_di_o,
  input  logic [15:0] drp_do_i,
  input  logic        drp_drdy_i,
  output logic        mmcm_rst_o,
  input  logic        mmcm_locked_i
);

  localparam logic [15:0] RST_LD  = 16'(RST_CYCLES - 1);
  localparam logic [15:0] DRDY_LD = 16'(DRDY_TIMEOUT - 1);
  localparam logic [15:0] LOCK_LD = 16'(LOCK_TIMEOUT - 1);

  state_e      state_q, state_d;
  err_e        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] rd_q, rd_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  cur_q, cur_d;
  logic        done_q, done_d;
  logic        tmo_q, tmo_d;

  logic [7:0]  enc_div;
  div_fields_t f;
  logic [15:0] reg1_new;
  logic [15:0] reg2_new;
  logic        cnt_zero;

  // Idle validates the incoming request; later states use the latched one
  assign enc_div = (state_q == S_IDLE) ? req_div_i : div_q;

  rvlab_clk_div_encode u_enc (
    .div_i    (enc_div),
    .fields_o (f)
  );

  assign reg1_new = (rd_q & CLKREG1_KEEP)
                  | (16'(f.high) << HIGH_OFS)
                  | (16'(f.low) << LOW_OFS);
  assign reg2_new = (rd_q & CLKREG2_KEEP)
                  | (16'(f.edge_bit) << EDGE_OFS)
                  | (16'(f.no_count) << NOCNT_OFS);

  assign cnt_zero = (cnt_q == 16'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      err_q   <= ErrNone;
      cnt_q   <= 16'd0;
      rd_q    <= 16'd0;
      div_q   <= 8'd0;
      cur_q   <= RESET_DIV;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      div_q   <= div_d;
      cur_q   <= cur_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - 16'd1;
    rd_d    = rd_q;
    div_d   = div_q;
    cur_d   = cur_q;
    done_d  = 1'b0;
    tmo_d   = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          if (f.valid) begin
            state_d = S_HOLD_RST;
            cnt_d   = RST_LD;
            div_d   = req_div_i;
            tmo_d   = 1'b0;
          end else begin
            done_d = 1'b1;
            err_d  = ErrBadDiv;
          end
        end
      end
      S_HOLD_RST: begin
        if (cnt_zero) state_d = S_RD1;
      end
      S_RD1: begin
        state_d = S_WAIT_R1;
        cnt_d   = DRDY_LD;
      end
      S_WAIT_R1: begin
        if (drp_drdy_i) begin
          rd_d    = drp_do_i;
          state_d = S_WR1;
        end else if (cnt_zero) begin
          tmo_d   = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_WR1: begin
        state_d = S_WAIT_W1;
        cnt_d   = DRDY_LD;
      end
      S_WAIT_W1: begin
        if (drp_drdy_i) begin
          state_d = S_RD2;
        end else if (cnt_zero) begin
          tmo_d   = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_RD2: begin
        state_d = S_WAIT_R2;
        cnt_d   = DRDY_LD;
      end
      S_WAIT_R2: begin
        if (drp_drdy_i) begin
          rd_d    = drp_do_i;
          state_d = S_WR2;
        end else if (cnt_zero) begin
          tmo_d   = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_WR2: begin
        state_d = S_WAIT_W2;
        cnt_d   = DRDY_LD;
      end
      S_WAIT_W2: begin
        if (drp_drdy_i) begin
          state_d = S_RELEASE;
        end else if (cnt_zero) begin
          tmo_d   = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (tmo_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = ErrDrpTimeout;
        end else begin
          state_d = S_WAIT_LOCK;
          cnt_d   = LOCK_LD;
        end
      end
      S_WAIT_LOCK: begin
        // first cycle ignored: locked may still be stale from before reset
        if (mmcm_locked_i && cnt_q != LOCK_LD) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = ErrNone;
          cur_d   = div_q;
        end else if (cnt_zero) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = ErrLockTimeout;
          cur_d   = div_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign cur_div_o   = cur_q;

  assign drp_den_o  = state_q inside {S_RD1, S_WR1, S_RD2, S_WR2};
  assign drp_dwe_o  = state_q inside {S_WR1, S_WR2};
  assign mmcm_rst_o = state_q inside {S_HOLD_RST, S_RD1, S_WAIT_R1,
                                      S_WR1, S_WAIT_W1, S_RD2,
                                      S_WAIT_R2, S_WR2, S_WAIT_W2};

  always_comb begin
    drp_daddr_o = 7'd0;
    drp_di_o    = 16'd0;
    unique case (state_q)
      S_RD1:   drp_daddr_o = CLKREG1_ADDR;
      S_RD2:   drp_daddr_o = CLKREG2_ADDR;
      S_WR1: begin
        drp_daddr_o = CLKREG1_ADDR;
        drp_di_o    = reg1_new;
      end
      S_WR2: begin
        drp_daddr_o = CLKREG2_ADDR;
        drp_di_o    = reg2_new;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rvlab_clk_drp_seq.sv
// tb_rvlab_clk_drp_seq: scoreboard bench with DRP and MMCM lock models
// and a divider-field reference computed from plain arithmetic.
module tb_rvlab_clk_drp_seq;

  localparam logic [6:0]  A1 = 7'h08;
  localparam logic [6:0]  A2 = 7'h09;
  localparam logic [15:0] K1 = 16'h1000;
  localparam logic [15:0] K2 = 16'hFC00;
  localparam int RESET_DIV = 18;
  localparam int RST_CYC   = 4;
  localparam int DRDY_TO   = 64;
  localparam int LOCK_TO   = 65535;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic [7:0]  req_div = 8'd0;
  logic        req_ready_o, busy_o, done_o;
  logic [1:0]  err_o;
  logic [7:0]  cur_div_o;
  logic        drp_den_o, drp_dwe_o;
  logic [6:0]  drp_daddr_o;
  logic [15:0] drp_di_o;
  logic [15:0] drp_do = 16'd0;
  logic        drp_drdy = 1'b0;
  logic        mmcm_rst_o;
  logic        mmcm_locked = 1'b1;

  always #5 clk = ~clk;

  rvlab_clk_drp_seq dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready_o),
    .req_div_i     (req_div),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .cur_div_o     (cur_div_o),
    .drp_den_o     (drp_den_o),
    .drp_dwe_o     (drp_dwe_o),
    .drp_daddr_o   (drp_daddr_o),
    .drp_di_o      (drp_di_o),
    .drp_do_i      (drp_do),
    .drp_drdy_i    (drp_drdy),
    .mmcm_rst_o    (mmcm_rst_o),
    .mmcm_locked_i (mmcm_locked)
  );

  typedef struct packed {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] data;
  } drp_t;

  typedef struct packed {
    logic [1:0] err;
    logic [7:0] cur;
  } done_t;

  drp_t  exp_drp[$];
  done_t exp_done[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int t_rise = 0, t_fall = 0, t_wr1 = 0, t_done = 0;
  int t_first_den = -1, t_rd2 = -1, n_done = 0;
  int cur_model = RESET_DIV;

  logic [15:0] rd1_val = 16'hFFFF;
  logic [15:0] rd2_val = 16'hFFFF;
  int drp_lat = 2;
  bit drop_wr1 = 1'b0;
  bit lock_en = 1'b1;
  int lock_delay = 20;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: event seen, expected none", nm);
  endtask

  function automatic logic [15:0] ref_reg1(input int d,
                                           input logic [15:0] rd);
    int hi, lo;
    if (d == 1) begin
      hi = 1;
      lo = 1;
    end else begin
      hi = d / 2;
      lo = d - hi;
    end
    return (rd & K1) | 16'(hi * 64 + lo);
  endfunction

  function automatic logic [15:0] ref_reg2(input int d,
                                           input logic [15:0] rd);
    int e, nc;
    e  = (d == 1) ? 0 : d % 2;
    nc = (d == 1) ? 1 : 0;
    return (rd & K2) | 16'(e * 128 + nc * 64);
  endfunction

  // DRP slave model: answers each access after drp_lat cycles
  initial begin : drp_model
    int pend;
    logic [15:0] pdata;
    pend = 0;
    pdata = 16'd0;
    forever @(negedge clk) begin
      drp_drdy = 1'b0;
      drp_do   = 16'($urandom);
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            drp_drdy = 1'b1;
            drp_do   = pdata;
          end
        end
        if (pend == 0 && !busy_o && $urandom_range(0, 3) == 0)
          drp_drdy = 1'b1;
        if (drp_den_o &&
            !(drop_wr1 && drp_dwe_o && drp_daddr_o == A1)) begin
          pend = drp_lat;
          if (drp_dwe_o)
            pdata = 16'($urandom);
          else
            pdata = (drp_daddr_o == A1) ? rd1_val : rd2_val;
        end
      end
    end
  end

  initial begin : lock_model
    int lcnt;
    lcnt = 0;
    forever @(negedge clk) begin
      if (mmcm_rst_o) begin
        lcnt = 0;
        mmcm_locked = 1'b0;
      end else if (lock_en && !mmcm_locked) begin
        lcnt++;
        if (lcnt >= lock_delay) mmcm_locked = 1'b1;
      end
    end
  end

  initial begin : monitor
    logic prev_rst;
    drp_t  e;
    done_t dn;
    prev_rst = 1'b0;
    forever @(negedge clk) begin
      if (mmcm_rst_o && !prev_rst) t_rise = cyc;
      if (!mmcm_rst_o && prev_rst) t_fall = cyc;
      prev_rst = mmcm_rst_o;
      if (drp_dwe_o && !drp_den_o) flag("dwe_without_den");
      if (drp_den_o) begin
        if (t_first_den < 0) t_first_den = cyc;
        if (drp_dwe_o && drp_daddr_o == A1) t_wr1 = cyc;
        if (!drp_dwe_o && drp_daddr_o == A2) t_rd2 = cyc;
        check("drp_rst_held", mmcm_rst_o, 1);
        if (exp_drp.size() == 0) begin
          flag("drp_unexpected");
        end else begin
          e = exp_drp.pop_front();
          check("drp_we", drp_dwe_o, e.we);
          check("drp_addr", drp_daddr_o, e.addr);
          if (e.we) check("drp_wdata", drp_di_o, e.data);
        end
      end
      if (done_o) begin
        t_done = cyc;
        if (exp_done.size() == 0) begin
          flag("done_unexpected");
        end else begin
          dn = exp_done.pop_front();
          check("done_err", err_o, dn.err);
          check("done_cur_div", cur_div_o, dn.cur);
          check("done_rst_low", mmcm_rst_o, 0);
        end
        n_done++;
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_ready", req_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_cur_div", cur_div_o, RESET_DIV);
    check("rst_den", drp_den_o, 0);
    check("rst_dwe", drp_dwe_o, 0);
    check("rst_daddr", drp_daddr_o, 0);
    check("rst_di", drp_di_o, 0);
    check("rst_mmcm_rst", mmcm_rst_o, 0);
  endtask

  // lock_to: lock model disabled; busy-time request pulses injected
  task automatic issue(input int d, input bit lock_to);
    bit bad;
    int n0, t_acc, budget;
    bad = (d == 0 || d > 126);
    for (int i = 0; i < 200 && !req_ready_o; i++) @(negedge clk);
    check("ready_before_req", req_ready_o, 1);
    if (bad) begin
      exp_done.push_back('{err: 2'd1, cur: 8'(cur_model)});
    end else begin
      exp_drp.push_back('{we: 1'b0, addr: A1, data: 16'h0});
      exp_drp.push_back('{we: 1'b1, addr: A1,
                          data: ref_reg1(d, rd1_val)});
      if (drop_wr1) begin
        exp_done.push_back('{err: 2'd2, cur: 8'(cur_model)});
      end else begin
        exp_drp.push_back('{we: 1'b0, addr: A2, data: 16'h0});
        exp_drp.push_back('{we: 1'b1, addr: A2,
                            data: ref_reg2(d, rd2_val)});
        cur_model = d;
        exp_done.push_back('{err: lock_to ? 2'd3 : 2'd0,
                             cur: 8'(cur_model)});
      end
    end
    t_first_den = -1;
    n0 = n_done;
    t_acc = cyc;
    req_valid = 1'b1;
    req_div = 8'(d);
    @(negedge clk);
    req_valid = 1'b0;
    req_div = 8'($urandom);
    budget = lock_to ? LOCK_TO + 400 : 400;
    for (int i = 0; i < budget && n_done == n0; i++) begin
      if (lock_to && i % 5000 == 100) begin
        check("ready_low_busy", req_ready_o, 0);
        req_valid = 1'b1;
        req_div = 8'($urandom_range(1, 126));
        @(negedge clk);
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    if (n_done == n0) begin
      flag("done_timeout");
      exp_drp.delete();
      exp_done.delete();
    end
    check("queues_drained", exp_drp.size() + exp_done.size(), 0);
    check("cur_div_after", cur_div_o, cur_model);
    if (bad) begin
      check("bad_done_latency", t_done - t_acc, 1);
    end else begin
      check("hold_rst_len", t_first_den - t_rise, RST_CYC);
      if (drop_wr1) begin
        check("drdy_to_rst_fall", t_fall - (t_wr1 + 1), DRDY_TO);
        check("drdy_to_done", t_done - (t_wr1 + 1), DRDY_TO + 1);
      end else if (lock_to) begin
        check("lock_to_done", t_done - t_fall, LOCK_TO + 1);
      end else begin
        check("lock_done_latency", t_done - t_fall, lock_delay);
      end
    end
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    #2 rst_n = 1'b0;
    #20 check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    rd1_val = 16'hFFFF;
    rd2_val = 16'hFFFF;
    issue(18, 1'b0);
    rd1_val = 16'h0000;
    rd2_val = 16'h0000;
    issue(7, 1'b0);
    issue(1, 1'b0);
    issue(126, 1'b0);
    issue(0, 1'b0);
    issue(127, 1'b0);
    issue(255, 1'b0);

    drop_wr1 = 1'b1;
    rd1_val = 16'h5A5A;
    issue(50, 1'b0);
    drop_wr1 = 1'b0;

    for (int k = 0; k < 14; k++) begin
      rd1_val = 16'($urandom);
      rd2_val = 16'($urandom);
      drp_lat = $urandom_range(1, 6);
      lock_delay = $urandom_range(3, 30);
      issue($urandom_range(0, 130), 1'b0);
    end

    lock_en = 1'b0;
    issue(33, 1'b1);
    lock_en = 1'b1;
    lock_delay = 20;

    // reset while waiting for the ClkReg2 read data
    drp_lat = 20;
    for (int i = 0; i < 200 && !req_ready_o; i++) @(negedge clk);
    exp_drp.push_back('{we: 1'b0, addr: A1, data: 16'h0});
    exp_drp.push_back('{we: 1'b1, addr: A1,
                        data: ref_reg1(60, rd1_val)});
    exp_drp.push_back('{we: 1'b0, addr: A2, data: 16'h0});
    t_rd2 = -1;
    req_valid = 1'b1;
    req_div = 8'd60;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 400 && t_rd2 < 0; i++) @(negedge clk);
    check("rd2_reached", t_rd2 >= 0, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    exp_drp.delete();
    exp_done.delete();
    cur_model = RESET_DIV;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drp_lat = 3;
    repeat (2) @(negedge clk);
    issue(40, 1'b0);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
